// File: rtl/ps2_scan2ascii_fifo.sv
// PS/2 set-2 scan code to ASCII converter with output FIFO.
// Tracks E0/F0 prefixes, Shift, Ctrl and Caps Lock, decodes each key byte
// into an ASCII entry one edge after the byte arrives, and writes that entry
// into a first-word-fall-through FIFO on the following edge.
module ps2_scan2ascii_fifo #(
    parameter int FIFO_DEPTH   = 8,
    parameter int EMIT_RELEASE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         scan_valid,
    input  logic [7:0]                   scan_code,
    input  logic                         rd_en,
    input  logic                         ovf_clr,
    output logic                         out_valid,
    output logic [7:0]                   out_data,
    output logic                         out_release,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow,
    output logic                         caps_lock,
    output logic                         shift,
    output logic                         ctrl
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

    // Map entry layout: {mapped, is_letter, unshifted[7:0], shifted[7:0]}
    function automatic logic [17:0] letter_ent(input logic [7:0] lower);
        return {2'b11, lower, lower - 8'h20};
    endfunction

    function automatic logic [17:0] sym_ent(input logic [7:0] u, input logic [7:0] s);
        return {2'b10, u, s};
    endfunction

    function automatic logic [17:0] key_map(input logic [7:0] code);
        case (code)
            8'h1C: return letter_ent(8'h61); 8'h32: return letter_ent(8'h62);
            8'h21: return letter_ent(8'h63); 8'h23: return letter_ent(8'h64);
            8'h24: return letter_ent(8'h65); 8'h2B: return letter_ent(8'h66);
            8'h34: return letter_ent(8'h67); 8'h33: return letter_ent(8'h68);
            8'h43: return letter_ent(8'h69); 8'h3B: return letter_ent(8'h6A);
            8'h42: return letter_ent(8'h6B); 8'h4B: return letter_ent(8'h6C);
            8'h3A: return letter_ent(8'h6D); 8'h31: return letter_ent(8'h6E);
            8'h44: return letter_ent(8'h6F); 8'h4D: return letter_ent(8'h70);
            8'h15: return letter_ent(8'h71); 8'h2D: return letter_ent(8'h72);
            8'h1B: return letter_ent(8'h73); 8'h2C: return letter_ent(8'h74);
            8'h3C: return letter_ent(8'h75); 8'h2A: return letter_ent(8'h76);
            8'h1D: return letter_ent(8'h77); 8'h22: return letter_ent(8'h78);
            8'h35: return letter_ent(8'h79); 8'h1A: return letter_ent(8'h7A);
            8'h16: return sym_ent(8'h31, 8'h21); 8'h1E: return sym_ent(8'h32, 8'h40);
            8'h26: return sym_ent(8'h33, 8'h23); 8'h25: return sym_ent(8'h34, 8'h24);
            8'h2E: return sym_ent(8'h35, 8'h25); 8'h36: return sym_ent(8'h36, 8'h5E);
            8'h3D: return sym_ent(8'h37, 8'h26); 8'h3E: return sym_ent(8'h38, 8'h2A);
            8'h46: return sym_ent(8'h39, 8'h28); 8'h45: return sym_ent(8'h30, 8'h29);
            8'h4E: return sym_ent(8'h2D, 8'h5F); 8'h55: return sym_ent(8'h3D, 8'h2B);
            8'h54: return sym_ent(8'h5B, 8'h7B); 8'h5B: return sym_ent(8'h5D, 8'h7D);
            8'h5D: return sym_ent(8'h5C, 8'h7C); 8'h4C: return sym_ent(8'h3B, 8'h3A);
            8'h52: return sym_ent(8'h27, 8'h22); 8'h0E: return sym_ent(8'h60, 8'h7E);
            8'h41: return sym_ent(8'h2C, 8'h3C); 8'h49: return sym_ent(8'h2E, 8'h3E);
            8'h4A: return sym_ent(8'h2F, 8'h3F);
            8'h29: return sym_ent(8'h20, 8'h20); 8'h5A: return sym_ent(8'h0D, 8'h0D);
            8'h66: return sym_ent(8'h08, 8'h08); 8'h0D: return sym_ent(8'h09, 8'h09);
            8'h76: return sym_ent(8'h1B, 8'h1B);
            default: return 18'h0;
        endcase
    endfunction

    state_t          state_reg, state_next;
    logic            lshift_reg, lshift_next, rshift_reg, rshift_next;
    logic            lctrl_reg, lctrl_next, rctrl_reg, rctrl_next;
    logic            caps_reg, caps_next;
    logic            push_valid_reg, push_valid_next;
    logic [8:0]      push_entry_reg, push_entry_next;
    logic            key_valid, code_ext, code_brk, shift_cur, ctrl_cur;
    logic [17:0]     map_ent;
    logic [7:0]      map_ascii;

    logic [8:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic            overflow_reg;
    logic            fifo_full, do_push, do_pop, drop;

    // Prefix FSM, modifier tracking and key decode for the incoming byte
    always_comb begin
        state_next      = state_reg;
        key_valid       = 1'b0;
        lshift_next     = lshift_reg;
        rshift_next     = rshift_reg;
        lctrl_next      = lctrl_reg;
        rctrl_next      = rctrl_reg;
        caps_next       = caps_reg;
        code_ext        = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);
        code_brk        = (state_reg == ST_BRK) || (state_reg == ST_EXT_BRK);
        shift_cur       = lshift_reg | rshift_reg;
        ctrl_cur        = lctrl_reg | rctrl_reg;
        map_ent         = 18'h0;
        map_ascii       = 8'h00;
        push_valid_next = 1'b0;
        push_entry_next = 9'h0;

        if (scan_valid) begin
            if (scan_code == 8'hE0 && (state_reg == ST_IDLE || state_reg == ST_EXT))
                state_next = ST_EXT;
            else if (scan_code == 8'hF0 && (state_reg == ST_IDLE || state_reg == ST_BRK))
                state_next = ST_BRK;
            else if (scan_code == 8'hF0 && state_reg == ST_EXT)
                state_next = ST_EXT_BRK;
            else begin
                key_valid  = 1'b1;
                state_next = ST_IDLE;
            end
        end

        // Modifier updates; extended variants other than right Ctrl are ignored
        if (key_valid) begin
            if (!code_ext) begin
                if (scan_code == 8'h12) lshift_next = !code_brk;
                if (scan_code == 8'h59) rshift_next = !code_brk;
                if (scan_code == 8'h14) lctrl_next  = !code_brk;
                if (scan_code == 8'h58 && !code_brk) caps_next = !caps_reg;
            end else if (scan_code == 8'h14) begin
                rctrl_next = !code_brk;
            end
        end

        // ASCII uses the modifier state as it was before this byte
        if (!code_ext)
            map_ent = key_map(scan_code);
        else if (scan_code == 8'h5A)
            map_ent = sym_ent(8'h0D, 8'h0D);
        else if (scan_code == 8'h4A)
            map_ent = sym_ent(8'h2F, 8'h2F);

        if (map_ent[16]) begin
            if (ctrl_cur)
                map_ascii = map_ent[7:0] & 8'h1F;
            else
                map_ascii = (shift_cur ^ caps_reg) ? map_ent[7:0] : map_ent[15:8];
        end else begin
            map_ascii = shift_cur ? map_ent[7:0] : map_ent[15:8];
        end

        push_valid_next = key_valid && map_ent[17] && (!code_brk || EMIT_RELEASE != 0);
        push_entry_next = {code_brk, map_ascii};
    end

    // Decoder state and the registered decoded entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            lshift_reg     <= 1'b0;
            rshift_reg     <= 1'b0;
            lctrl_reg      <= 1'b0;
            rctrl_reg      <= 1'b0;
            caps_reg       <= 1'b0;
            push_valid_reg <= 1'b0;
            push_entry_reg <= 9'h0;
        end else begin
            state_reg      <= state_next;
            lshift_reg     <= lshift_next;
            rshift_reg     <= rshift_next;
            lctrl_reg      <= lctrl_next;
            rctrl_reg      <= rctrl_next;
            caps_reg       <= caps_next;
            push_valid_reg <= push_valid_next;
            push_entry_reg <= push_entry_next;
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle
    always_comb begin
        fifo_full = (count_reg == DEPTH_CNT);
        do_pop    = rd_en && (count_reg != '0);
        do_push   = push_valid_reg && (!fifo_full || do_pop);
        drop      = push_valid_reg && fifo_full && !do_pop;
    end

    // FIFO storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= push_entry_reg;
    end

    // FIFO pointers, occupancy and sticky overflow (a drop beats ovf_clr)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)
                count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push)
                count_reg <= count_reg - 1'b1;
            if (drop)
                overflow_reg <= 1'b1;
            else if (ovf_clr)
                overflow_reg <= 1'b0;
        end
    end

    assign out_valid   = (count_reg != '0);
    assign out_data    = out_valid ? mem[rd_ptr_reg][7:0] : 8'h00;
    assign out_release = out_valid ? mem[rd_ptr_reg][8] : 1'b0;
    assign fifo_count  = count_reg;
    assign overflow    = overflow_reg;
    assign caps_lock   = caps_reg;
    assign shift       = lshift_reg | rshift_reg;
    assign ctrl        = lctrl_reg | rctrl_reg;

endmodule
